// File: rtl/bp_pkg.sv
// Shared branch-prediction types, counter constants and helpers.
// Imported by the BTB and any other predictor in the BP group.
package bp_pkg;

  localparam int BP_WIDTH = 32;
  localparam int BP_TAG_W = 8;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_WEAK_TAKEN = 2'b10;
  localparam ctr_t CTR_MAX        = 2'b11;
  localparam ctr_t CTR_MIN        = 2'b00;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_WIDTH-1:0] target;
    ctr_t                ctr;
  } btb_entry_t;

  typedef enum logic {
    BTB_INIT,
    BTB_READY
  } btb_state_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == CTR_MAX) ? CTR_MAX : c + 2'd1;
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == CTR_MIN) ? CTR_MIN : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state function.
// Pure combinational; state lives with the caller.
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  assign ctr_next = taken ? sat_inc(ctr) : sat_dec(ctr);

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational fetch lookup, EX-stage training,
// valid bits cleared by a one-entry-per-cycle sweep after reset/flush.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC_F,
  input  logic [WIDTH-1:0] PC_EX,
  input  logic [WIDTH-1:0] target_EX,
  input  logic             branch_en_EX,
  input  logic             feedback_from_ALU,
  input  logic             flush_btb,
  output logic             hit_F,
  output logic             branch_en_F,
  output logic [WIDTH-1:0] PC_destination,
  output logic             ready
);

  localparam int TAG_HI = IDX_W + TAG_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_ex;
  logic [TAG_W-1:0] tag_f;
  logic [TAG_W-1:0] tag_ex;

  assign idx_f  = PC_F[IDX_W+1:2];
  assign idx_ex = PC_EX[IDX_W+1:2];
  assign tag_f  = PC_F[TAG_HI:IDX_W+2];
  assign tag_ex = PC_EX[TAG_HI:IDX_W+2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC_F[1:0], PC_F[WIDTH-1:TAG_HI+1],
                            PC_EX[1:0], PC_EX[WIDTH-1:TAG_HI+1]};

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [WIDTH-1:0]   tgt_q [ENTRIES];
  ctr_t               ctr_q [ENTRIES];

  btb_state_t       state_q;
  btb_state_t       state_d;
  logic [IDX_W-1:0] sweep_q;
  logic [IDX_W-1:0] sweep_d;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      BTB_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_IDX) state_d = BTB_READY;
      end
      BTB_READY: begin
        if (flush_btb) begin
          state_d = BTB_INIT;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = BTB_INIT;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BTB_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  logic active;
  assign ready  = (state_q == BTB_READY);
  assign active = ready && !rst;

  always_comb begin
    hit_F          = active && valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    branch_en_F    = hit_F && ctr_q[idx_f][1];
    PC_destination = hit_F ? tgt_q[idx_f] : '0;
  end

  logic ex_hit;
  logic upd;
  logic wr_hit;
  logic wr_alloc;
  ctr_t ctr_nxt;

  assign ex_hit   = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
  assign upd      = active && !flush_btb && branch_en_EX;
  assign wr_hit   = upd && ex_hit;
  assign wr_alloc = upd && !ex_hit && feedback_from_ALU;

  bp_sat_counter u_ctr (
    .ctr      (ctr_q[idx_ex]),
    .taken    (feedback_from_ALU),
    .ctr_next (ctr_nxt)
  );

  // Valid bits have no reset; the sweep is the only clear path.
  always_ff @(posedge clk) begin
    if (state_q == BTB_INIT) begin
      valid_q[sweep_q] <= 1'b0;
    end else if (wr_alloc) begin
      valid_q[idx_ex] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      ctr_q[idx_ex] <= ctr_nxt;
      if (feedback_from_ALU) tgt_q[idx_ex] <= target_EX;
    end else if (wr_alloc) begin
      tag_q[idx_ex] <= tag_ex;
      tgt_q[idx_ex] <= target_EX;
      ctr_q[idx_ex] <= CTR_WEAK_TAKEN;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
// Inputs change 1 time unit after the rising edge.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC_F = '0;
  logic [31:0] PC_EX = '0;
  logic [31:0] target_EX = '0;
  logic        branch_en_EX = 1'b0;
  logic        feedback_from_ALU = 1'b0;
  logic        flush_btb = 1'b0;
  logic        hit_F;
  logic        branch_en_F;
  logic [31:0] PC_destination;
  logic        ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .PC_F              (PC_F),
    .PC_EX             (PC_EX),
    .target_EX         (target_EX),
    .branch_en_EX      (branch_en_EX),
    .feedback_from_ALU (feedback_from_ALU),
    .flush_btb         (flush_btb),
    .hit_F             (hit_F),
    .branch_en_F       (branch_en_F),
    .PC_destination    (PC_destination),
    .ready             (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic tk);
    PC_EX             = pc;
    target_EX         = tgt;
    feedback_from_ALU = tk;
    branch_en_EX      = 1'b1;
    step();
    branch_en_EX      = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic h, input logic b,
                      input logic [31:0] d);
    PC_F = pc;
    #1;
    chk({tag, ".hit"}, 32'(hit_F), 32'(h));
    chk({tag, ".br"}, 32'(branch_en_F), 32'(b));
    chk({tag, ".dest"}, PC_destination, d);
  endtask

  // Counts cycles until ready, probing lookups along the way.
  task automatic wait_ready(output int n, output logic seen);
    n    = 0;
    seen = 1'b0;
    while (!ready && n < 200) begin
      PC_F = 32'h100 + 32'(n) * 4;
      #1;
      if (hit_F || branch_en_F || PC_destination != 0) seen = 1'b1;
      n++;
      step();
    end
  endtask

  int   cnt;
  logic seen;

  initial begin
    step();
    rst = 1'b0;
    wait_ready(cnt, seen);
    chk("reset.ready_cycles", 32'(cnt), 32'd64);
    chk("reset.no_hit", 32'(seen), 32'd0);
    chk("reset.ready", 32'(ready), 32'd1);

    upd(32'h100, 32'h40, 1'b1);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h40);
    look("alloc_lowbits", 32'h103, 1'b1, 1'b1, 32'h40);

    upd(32'h100, 32'h40, 1'b1);
    look("ctr_t1", 32'h100, 1'b1, 1'b1, 32'h40);
    upd(32'h100, 32'h40, 1'b1);
    look("ctr_t2", 32'h100, 1'b1, 1'b1, 32'h40);
    upd(32'h100, 32'h40, 1'b1);
    look("ctr_t3", 32'h100, 1'b1, 1'b1, 32'h40);
    upd(32'h100, 32'h40, 1'b0);
    look("ctr_n1", 32'h100, 1'b1, 1'b1, 32'h40);
    upd(32'h100, 32'h40, 1'b0);
    look("ctr_n2", 32'h100, 1'b1, 1'b0, 32'h40);

    upd(32'h200, 32'h80, 1'b1);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h200, 1'b1, 1'b1, 32'h80);

    upd(32'h10, 32'h5, 1'b0);
    look("miss_nt", 32'h10, 1'b0, 1'b0, 32'h0);

    upd(32'h100, 32'h40, 1'b1);
    PC_F              = 32'h100;
    PC_EX             = 32'h100;
    target_EX         = 32'h44;
    feedback_from_ALU = 1'b1;
    branch_en_EX      = 1'b1;
    #1;
    chk("coll.before", PC_destination, 32'h40);
    step();
    branch_en_EX = 1'b0;
    look("coll.after", 32'h100, 1'b1, 1'b1, 32'h44);

    repeat (4) upd(32'h100, 32'h0, 1'b0);
    look("ctr_floor", 32'h100, 1'b1, 1'b0, 32'h44);

    PC_EX             = 32'h300;
    target_EX         = 32'h99;
    feedback_from_ALU = 1'b1;
    branch_en_EX      = 1'b1;
    flush_btb         = 1'b1;
    step();
    branch_en_EX = 1'b0;
    flush_btb    = 1'b0;
    wait_ready(cnt, seen);
    chk("flush.ready_cycles", 32'(cnt), 32'd64);
    chk("flush.no_hit", 32'(seen), 32'd0);
    look("flush.old100", 32'h100, 1'b0, 1'b0, 32'h0);
    look("flush.old200", 32'h200, 1'b0, 1'b0, 32'h0);
    look("flush.drop300", 32'h300, 1'b0, 1'b0, 32'h0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    upd(32'h400, 32'h77, 1'b1);
    wait_ready(cnt, seen);
    chk("init.ready_cycles", 32'(cnt), 32'd63);
    look("init.drop400", 32'h400, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Direct-mapped branch target buffer sitting directly upstream of the loop detector in the BP_Modules group. Looked up combinationally with the fetch PC. Supplies the predicted-taken flag (branch_en_F) and the predicted target (PC_destination) that the loop detector consumes in the same cycle. Trained from the EX stage with resolved branch outcomes and targets.

Parameters:
WIDTH, 32, PC/target width (from Header_File.svh)
ENTRIES, 64, number of BTB entries; power of two
IDX_W, $clog2(ENTRIES), index width
TAG_W, 8, stored partial-tag width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
PC_F  input  WIDTH  fetch-stage PC
PC_EX  input  WIDTH  PC of branch resolving in EX
target_EX  input  WIDTH  resolved branch target from EX
branch_en_EX  input  1  EX holds a valid conditional branch this cycle
feedback_from_ALU  input  1  resolved direction (1 = taken); valid with branch_en_EX
flush_btb  input  1  invalidate all entries (context switch / fence)
hit_F  output  1  PC_F matches a valid entry
branch_en_F  output  1  hit_F and counter predicts taken
PC_destination  output  WIDTH  predicted target; 0 when hit_F = 0
ready  output  1  1 when the table is usable (not sweeping)

Behaviour:
- Index = PC[IDX_W+1:2]; tag = PC[IDX_W+TAG_W+1:IDX_W+2]. Bits [1:0] are ignored.
- Entry contents: valid (1), tag (TAG_W), target (WIDTH), ctr (2-bit saturating; 00 = strongly not-taken … 11 = strongly taken).
- Arrays hold no reset. The valid bits are cleared by a sweep FSM.
- FSM states:
  - INIT: clear valid[sweep_idx]; sweep_idx increments each cycle. Leaves for READY after clearing index ENTRIES-1. Duration is exactly ENTRIES cycles.
  - READY: normal operation.
- FSM transitions:
  - rst = 1 → INIT with sweep_idx = 0, from any state (reset mid-sweep restarts the sweep).
  - flush_btb = 1 in READY → INIT next cycle. flush_btb in INIT is ignored.
- Outputs:
  - ready = 1 only in READY. ready is registered.
  - During rst and INIT: hit_F = 0, branch_en_F = 0, PC_destination = 0.
- Lookup (READY): purely combinational, zero latency.
  - hit_F = valid & tag match.
  - branch_en_F = hit_F & ctr[1].
  - PC_destination = hit_F ? target : 0.
- Update: registered, visible to lookups from the next cycle. Applied only in READY when branch_en_EX = 1.
  - Hit, taken: ctr = sat_inc(ctr); target ← target_EX.
  - Hit, not taken: ctr = sat_dec(ctr). Target unchanged. The entry stays valid even at 00.
  - Miss, taken: allocate/overwrite. valid = 1, tag, target = target_EX, ctr = 2'b10.
  - Miss, not taken: no change.
- Saturation: 11 + taken stays 11; 00 + not-taken stays 00. There is no wrap-around.
- Same-cycle lookup and update at the same index: the lookup returns the pre-update contents (read-before-write).
- Simultaneous flush_btb and branch_en_EX: flush wins and the update is dropped.
- Update arriving during INIT is dropped.

Decomposition:
- Shared package bp_pkg:
  - btb_entry_t struct (valid, tag, target, ctr)
  - ctr_t 2-bit type
  - constants CTR_WEAK_TAKEN = 2'b10, CTR_MAX = 2'b11, CTR_MIN = 2'b00
  - btb_state_t enum {BTB_INIT, BTB_READY}
  - sat_inc / sat_dec functions (reused by other predictors)
- One sub-module, bp_sat_counter: a 2-bit saturating counter next-state function with inputs ctr, taken and output ctr_next. It is instantiated in the update path.

Test Plan:
- Reset sweep: assert rst 1 cycle, release.
  - ready = 0 for exactly 64 cycles, then 1.
  - hit_F = 0 for any PC_F throughout.
- Allocation: taken update PC_EX = 0x0000_0100, target_EX = 0x0000_0040.
  - Next cycle, PC_F = 0x100 gives hit_F = 1, branch_en_F = 1, PC_destination = 0x40.
- Counter saturation and hysteresis: starting from a fresh allocation (10), 3 taken then 2 not-taken updates.
  - ctr goes 11, 11, 11, 10, 01.
  - branch_en_F = 0 after the final update while hit_F stays 1.
- Aliasing: allocate 0x100, then taken update at 0x100 + (64 << 2) with a different tag.
  - Lookup of 0x100 misses; the new PC hits with its own target.
- Miss not-taken: update with feedback_from_ALU = 0 on an empty index.
  - Next-cycle lookup: hit_F = 0.
- Flush/collision:
  - flush_btb together with branch_en_EX: update dropped, ready = 0 for 64 cycles, all prior entries miss.
  - Same-cycle lookup and update of 0x100 returns the old target; the new target appears the following cycle.
